// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared definitions for the fetch stage and its neighbours.
//   - bus widths and the reset fetch address
//   - packed layouts of the branch bus (decode -> fetch) and the
//     fetch-to-decode bus, so that both ends pack and unpack fields in
//     the same order
package if_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;
    localparam int          BR_BUS_WD        = 33;
    localparam int          FS_TO_DS_BUS_WD  = 64;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_to_ds_bus_t;

endpackage

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage LoongArch32 pipeline.
//   Owns the PC and the pre-IF nextpc mux, drives the synchronous inst
//   SRAM (1-cycle read latency) and hands {pc, inst} to decode over a
//   valid/allowin handshake. Branch redirects from decode cancel the
//   instruction in IF; a redirect that arrives while IF is blocked is
//   latched and fetched in the following cycle. The fetched word is
//   buffered while decode stalls, since the SRAM output is not held.
//
// Ports
//   clk              in   1   clock
//   reset            in   1   synchronous, active-high reset
//   ds_allowin       in   1   decode can accept an instruction this cycle
//   br_bus           in   33  {br_taken, br_target}
//   fs_to_ds_valid   out  1   fs_to_ds_bus carries a valid instruction
//   fs_to_ds_bus     out  64  {fs_pc, fs_inst}
//   inst_sram_en     out  1   read enable
//   inst_sram_we     out  4   always 0
//   inst_sram_addr   out  32  nextpc
//   inst_sram_wdata  out  32  always 0
//   inst_sram_rdata  in   32  data for the previous enabled address
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_en,
    output logic [3:0]                 inst_sram_we,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic [31:0]                inst_sram_rdata
);

    br_bus_t       br;
    fs_to_ds_bus_t ds_bus;

    logic        to_fs_valid;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        br_pend;
    logic [31:0] br_target_r;
    logic        buf_valid;
    logic [31:0] inst_buf;

    logic [31:0] nextpc;
    logic        fs_allowin;
    logic        fs_fetch;
    logic        br_stalled;

    assign br = br_bus;

    // Newest redirect first, then a redirect held over from a blocked cycle.
    assign nextpc = br.taken ? br.target :
                    br_pend  ? br_target_r :
                               fs_pc + 32'd4;

    assign fs_allowin = ~fs_valid | ds_allowin;

    // Reset gates the request so nothing reaches the SRAM in the first
    // reset cycle, while to_fs_valid still holds its pre-reset value.
    assign fs_fetch   = to_fs_valid & fs_allowin & ~reset;

    // Redirect that cannot be fetched this cycle because IF is blocked.
    assign br_stalled = br.taken & ~fs_allowin;

    assign inst_sram_en    = fs_fetch;
    assign inst_sram_we    = 4'h0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'h0;

    assign fs_to_ds_valid = fs_valid & ~br.taken;
    assign ds_bus.pc      = fs_pc;
    assign ds_bus.inst    = buf_valid ? inst_buf : inst_sram_rdata;
    assign fs_to_ds_bus   = ds_bus;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_fs_valid <= 1'b0;
            fs_valid    <= 1'b0;
            fs_pc       <= RESET_PC - 32'd4;
            br_pend     <= 1'b0;
            buf_valid   <= 1'b0;
        end else begin
            to_fs_valid <= 1'b1;

            // A blocked redirect empties IF so the latched target can be
            // fetched next cycle without waiting for decode.
            if (br_stalled) begin
                fs_valid <= 1'b0;
            end else if (fs_allowin) begin
                fs_valid <= to_fs_valid;
            end

            // The PC only advances when a request is actually issued, so
            // the idle cycle right after reset keeps RESET_PC-4.
            if (fs_fetch) begin
                fs_pc <= nextpc;
            end

            if (br_stalled) begin
                br_pend <= 1'b1;
            end else if (fs_fetch) begin
                br_pend <= 1'b0;
            end

            if (br.taken || ds_allowin) begin
                buf_valid <= 1'b0;
            end else if (fs_valid && !buf_valid) begin
                buf_valid <= 1'b1;
            end
        end
    end

    // Data-only registers; qualified by br_pend / buf_valid.
    always_ff @(posedge clk) begin
        if (br.taken) begin
            br_target_r <= br.target;
        end
        if (fs_valid && !ds_allowin && !buf_valid && !br.taken) begin
            inst_buf <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ds_allowin      (ds_allowin),
        .br_bus          (br_bus),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a5a_3c3c;
    endfunction

    // Synchronous SRAM; output is garbage in cycles without a request.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
        else              inst_sram_rdata <= $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: which pc occupies IF, and when the next
    // one arrives (arrival countdown) and from which address.
    bit          m_has;
    logic [31:0] m_pc;
    int          m_cnt;
    logic [31:0] m_arr;
    bit          started;

    task automatic cycle(input bit r, input bit ds, input bit br, input logic [31:0] tgt);
        bit exp_valid;
        bit exp_en;
        @(negedge clk);
        reset      = r;
        ds_allowin = ds;
        br_bus     = {br, tgt};
        #1;
        check("we_zero", {28'h0, inst_sram_we}, 32'h0);
        check("wdata_zero", inst_sram_wdata, 32'h0);
        if (r) begin
            check("en_in_reset", {31'h0, inst_sram_en}, 32'h0);
            m_has   = 1'b0;
            m_cnt   = 2;
            m_arr   = RST_PC;
            started = 1'b0;
        end else begin
            exp_valid = m_has && !br;
            check("valid", {31'h0, fs_to_ds_valid}, {31'h0, exp_valid});
            if (exp_valid) begin
                check("pc", fs_to_ds_bus[63:32], m_pc);
                check("inst", fs_to_ds_bus[31:0], mem_word(m_pc));
            end
            if (br) begin
                m_cnt = (m_has && !ds) ? 2 : 1;
                m_arr = tgt;
                m_has = 1'b0;
            end else if (m_has && ds) begin
                m_cnt = 1;
                m_arr = m_pc + 32'd4;
                m_has = 1'b0;
            end
            exp_en = (m_cnt == 1);
            check("en", {31'h0, inst_sram_en}, {31'h0, exp_en});
            if (exp_en) check("addr", inst_sram_addr, m_arr);
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_has   = 1'b1;
                    m_pc    = m_arr;
                    started = 1'b1;
                end
            end
        end
    endtask

    typedef struct {
        bit          ds;
        bit          br;
        logic [31:0] tgt;
        bit          exp_valid;
        logic [31:0] exp_pc;
        bit          exp_en;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tgt;
        bit          br;
        bit          ds;
        int          guard;

        vecs[0]  = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0,          1'b1, 32'h1c00_0000};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h1c00_0000,  1'b1, 32'h1c00_0004};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h1c00_0004,  1'b1, 32'h1c00_0008};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h1c00_0008,  1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h1c00_0008,  1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'h1c00_0008,  1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h1c00_0008,  1'b1, 32'h1c00_000c};
        vecs[8]  = '{1'b1, 1'b1, 32'h1c00_0100,  1'b0, 32'h0,          1'b1, 32'h1c00_0100};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h1c00_0100,  1'b1, 32'h1c00_0104};
        vecs[10] = '{1'b0, 1'b1, 32'h1c00_0200,  1'b0, 32'h0,          1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,          1'b0, 32'h0,          1'b1, 32'h1c00_0200};
        vecs[12] = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h1c00_0200,  1'b1, 32'h1c00_0204};

        reset      = 1'b1;
        ds_allowin = 1'b0;
        br_bus     = '0;

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 13; i++) begin
            cycle(1'b0, vecs[i].ds, vecs[i].br, vecs[i].tgt);
            check($sformatf("vec%0d_valid", i), {31'h0, fs_to_ds_valid}, {31'h0, vecs[i].exp_valid});
            check($sformatf("vec%0d_en", i), {31'h0, inst_sram_en}, {31'h0, vecs[i].exp_en});
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_pc", i), fs_to_ds_bus[63:32], vecs[i].exp_pc);
                check($sformatf("vec%0d_inst", i), fs_to_ds_bus[31:0], mem_word(vecs[i].exp_pc));
            end
            if (vecs[i].exp_en)
                check($sformatf("vec%0d_addr", i), inst_sram_addr, vecs[i].exp_addr);
        end

        // Random traffic: stalls, redirects (incl. wraparound targets).
        for (int i = 0; i < 600; i++) begin
            ds = ($urandom_range(0, 3) != 0);
            br = started && ($urandom_range(0, 6) == 0);
            tgt = $urandom & 32'hffff_fffc;
            if ($urandom_range(0, 9) == 0) tgt = 32'hffff_fff8;
            cycle(1'b0, ds, br, tgt);
        end

        // Reset while a blocked redirect is pending.
        guard = 0;
        while (!m_has && guard < 10) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            guard++;
        end
        check("reach_valid", {31'h0, m_has}, 32'h1);
        cycle(1'b0, 1'b0, 1'b1, 32'h1c00_0300);
        check("stall_br_en", {31'h0, inst_sram_en}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("rst_pend_en", {31'h0, inst_sram_en}, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("rst_valid", {31'h0, fs_to_ds_valid}, 32'h0);
        check("rst_en", {31'h0, inst_sram_en}, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("rel0_en", {31'h0, inst_sram_en}, 32'h0);
        check("rel0_valid", {31'h0, fs_to_ds_valid}, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("rel1_en", {31'h0, inst_sram_en}, 32'h1);
        check("rel1_addr", inst_sram_addr, RST_PC);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("rel2_valid", {31'h0, fs_to_ds_valid}, 32'h1);
        check("rel2_pc", fs_to_ds_bus[63:32], RST_PC);
        check("rel2_inst", fs_to_ds_bus[31:0], mem_word(RST_PC));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
